// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader, fetch stage and instruction memory.
package imem_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CHK  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LEN  = ST_LEN,
        DATA = ST_DATA,
        CHK  = ST_CHK,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Frame loader (length, bytes, checksum) writing instruction memory; writes land 1 cycle after acceptance.
// in_ready is a pure state decode, so the stream may stall in any state without side effects.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.master bus,
    output logic         core_rst_n,
    output logic         done,
    output logic         error
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready;
    logic              accept;
    logic [ADDR_W-1:0] last_idx;

    assign ready  = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
    assign accept = ready && bus.in_valid;
    // cnt_q = 0 encodes a full 2^ADDR_W frame, so the last index wraps to all-ones
    assign last_idx = cnt_q - ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            LEN: begin
                if (accept) begin
                    cnt_d   = ADDR_W'(bus.in_data);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = bus.in_data;
                    idx_d   = idx_q + ADDR_W'(1);
                    acc_d   = acc_q + bus.in_data;
                    if (idx_q == last_idx) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    state_d = (bus.in_data == acc_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign core_rst_n    = (state_q == DONE);
    assign done          = (state_q == DONE);
    assign error         = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames, a table of random frames and a reference write model.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic core_rst_n, done, error;

    imem_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    imem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .core_rst_n(core_rst_n),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t wr_log[$];

    logic data_beat;
    logic exp_we;
    bit   mon_en;

    typedef struct {
        int n;
        int chk_delta;
        int gap_pct;
        bit exp_done;
        bit exp_err;
        bit exp_rstn;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A write is expected exactly one cycle after an instruction byte is offered and accepted.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mem_we_timing", bus.mem_we, exp_we);
            if (bus.mem_we) wr_log.push_back('{bus.mem_addr, bus.mem_wdata});
            exp_we = bus.in_valid && data_beat;
        end
    end

    task automatic beat(input logic [7:0] b, input bit is_data, input int gap_pct, input bit pulse_start);
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            data_beat    = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        data_beat    = is_data;
        start        = pulse_start;
        check("in_ready_in_frame", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        data_beat    = 1'b0;
        start        = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] data[$], input logic [7:0] chk,
                              input int gap_pct, input int start_at);
        wr_log.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("core_rst_n_after_start", core_rst_n, 1'b0);
        check("done_after_start", done, 1'b0);
        check("error_after_start", error, 1'b0);
        beat(len, 1'b0, gap_pct, 1'b0);
        foreach (data[i]) beat(data[i], 1'b1, gap_pct, (i == start_at));
        beat(chk, 1'b0, gap_pct, 1'b0);
        check("in_ready_after_chk", bus.in_ready, 1'b0);
    endtask

    function automatic logic [7:0] sum8(input logic [7:0] data[$]);
        int s = 0;
        foreach (data[i]) s += int'(data[i]);
        return 8'(s % 256);
    endfunction

    task automatic check_writes(input string name, input logic [7:0] data[$]);
        int bad = 0;
        check({name, "_wr_count"}, wr_log.size(), data.size());
        foreach (wr_log[i]) begin
            if (i < data.size()) begin
                if (wr_log[i].addr !== 8'(i) || wr_log[i].data !== data[i]) bad++;
            end
        end
        check({name, "_wr_content_errors"}, bad, 0);
    endtask

    task automatic check_status(input string name, input bit d, input bit e, input bit r);
        check({name, "_done"}, done, d);
        check({name, "_error"}, error, e);
        check({name, "_core_rst_n"}, core_rst_n, r);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_in_ready"}, bus.in_ready, 1'b0);
        check({name, "_mem_we"}, bus.mem_we, 1'b0);
        check({name, "_mem_addr"}, bus.mem_addr, 8'h00);
        check({name, "_mem_wdata"}, bus.mem_wdata, 8'h00);
        check_status(name, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d[$];
        logic [7:0] len;

        reset = 1'b1; start = 1'b0; mon_en = 1'b0; exp_we = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; data_beat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst_held");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst_idle");
        mon_en = 1'b1;

        d = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h03, d, 8'h66, 0, -1);
        check_writes("good3", d);
        check_status("good3", 1'b1, 1'b0, 1'b1);

        send_frame(8'h03, d, 8'h65, 0, -1);
        check_writes("bad3", d);
        check_status("bad3", 1'b0, 1'b1, 1'b0);

        d.delete();
        for (int i = 0; i < 256; i++) d.push_back(8'(i));
        send_frame(8'h00, d, 8'h80, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        check_writes("full256", d);
        check_status("full256", 1'b1, 1'b0, 1'b1);

        d = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h03, d, 8'h66, 40, 1);
        check_writes("gaps", d);
        check_status("gaps", 1'b1, 1'b0, 1'b1);

        d = '{8'hAA};
        send_frame(8'h01, d, 8'hAA, 0, -1);
        check_writes("restart", d);
        check_status("restart", 1'b1, 1'b0, 1'b1);

        // Abort a frame after its second instruction byte.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        beat(8'h04, 1'b0, 0, 1'b0);
        beat(8'h5A, 1'b1, 0, 1'b0);
        beat(8'hA5, 1'b1, 0, 1'b0);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_reset_values("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst_after");
        exp_we = 1'b0;
        mon_en = 1'b1;
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(8'h04, d, 8'h0A, 0, -1);
        check_writes("post_rst", d);
        check_status("post_rst", 1'b1, 1'b0, 1'b1);

        vecs = '{'{1, 0, 0, 1, 0, 1},
                 '{5, 0, 30, 1, 0, 1},
                 '{17, 1, 0, 0, 1, 0},
                 '{200, 0, 50, 1, 0, 1},
                 '{2, 255, 20, 0, 1, 0},
                 '{256, 0, 10, 1, 0, 1}};
        foreach (vecs[v]) begin
            d.delete();
            for (int i = 0; i < vecs[v].n; i++) d.push_back(8'($urandom_range(255)));
            len = 8'(vecs[v].n % 256);
            send_frame(len, d, 8'(int'(sum8(d)) + vecs[v].chk_delta), vecs[v].gap_pct,
                       int'($urandom_range(vecs[v].n - 1)));
            repeat (2) @(posedge clk);
            #1;
            check_writes($sformatf("vec%0d", v), d);
            check_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_rstn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
